// File: rtl/miner_pkg.sv
// Shared types and sizing helpers for the miner game's small control blocks.
package miner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } state_e;

   // Width of a down-counter that must hold values up to max(a,b)-1; never below 1 bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into fixed-width level pulses separated by a
// recovery gap; events arriving while busy are queued and replayed one pulse each.
module pulse_stretch
   import miner_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_count,
   output logic              overflow,
   output state_e            dbg_state
);

   localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   if (HIGH_CYCLES < 1) begin : g_bad_high
      $error("pulse_stretch: HIGH_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("pulse_stretch: GAP_CYCLES must be >= 1");
   end
   if (PEND_W < 1) begin : g_bad_pend
      $error("pulse_stretch: PEND_W must be >= 1");
   end

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              inc, dec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;
      inc     = 1'b0;
      dec     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The launching event goes straight to the output, never into the queue.
            if (pulse_in) begin
               state_d = HIGH;
               cnt_d   = HIGH_LOAD;
            end
         end
         HIGH: begin
            inc = pulse_in;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end
         end
         GAP: begin
            inc = pulse_in;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if ((pend_q != '0) || pulse_in) begin
               state_d = HIGH;
               cnt_d   = HIGH_LOAD;
               // An empty queue means this cycle's event is the one being replayed.
               if (pend_q != '0) dec = 1'b1;
               else              inc = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (inc && !dec) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + 1'b1;
      end else if (dec && !inc) begin
         pend_d = pend_q - 1'b1;
      end
   end

   assign level_out  = (state_q == HIGH);
   assign busy       = (state_q != IDLE);
   assign pend_count = pend_q;
   assign overflow   = ovf_q;
   assign dbg_state  = state_q;

endmodule
